complex_fifo_rd_sched: RTL and testbench

//  Read-side scheduler for two complex_fifo instances (one per RF channel).

---
 rtl/complex_fifo_rd_sched.sv | 270 +++++++++++++++++++++++++++
 tb/tb_complex_fifo_rd_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// complex_fifo_rd_sched
//
// Read-side scheduler for two complex_fifo instances, one per RF channel.
// It drains the FIFOs in bursts onto a single IQ word stream toward the host
// interface. Each output word is tagged with its source channel. A word is
// also flagged when it completes a full BURST_LEN burst.
//
// Both FIFOs have a 1-cycle read latency. The returning words are caught in a
// 2-entry output buffer. The head of that buffer drives the output port
// directly from flops.
//
// Configuration macro:
//   RD_SCHED_PRIO_EN  defined   : strict priority, ch0 whenever eligible
//                     undefined : round-robin between the two channels
//
// Parameters:
//   BURST_LEN  max words read from one channel per grant (2..256)
//   DATA_W     IQ word width
//
// Ports:
//   clk_i        clock shared with both FIFOs' read side
//   rst_n_i      asynchronous active-low reset
//   enable_i     scheduler enable; low only stops new reads
//   ch_en_i      per-channel enable mask
//   chN_empty_i  FIFO N empty flag
//   chN_data_i   FIFO N read data, valid one cycle after chN_rd_en_o
//   chN_rd_en_o  FIFO N read enable
//   m_data_o     output word
//   m_ch_o       source channel of m_data_o
//   m_last_o     word completes a full BURST_LEN burst
//   m_valid_o    output valid
//   m_ready_i    downstream ready; transfer = m_valid_o & m_ready_i
//   busy_o       FSM active or a word buffered / in flight
// ---------------------------------------------------------------------------
module complex_fifo_rd_sched #(
    parameter int BURST_LEN = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic [1:0]        ch_en_i,
    input  logic              ch0_empty_i,
    input  logic [DATA_W-1:0] ch0_data_i,
    output logic              ch0_rd_en_o,
    input  logic              ch1_empty_i,
    input  logic [DATA_W-1:0] ch1_data_i,
    output logic              ch1_rd_en_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_ch_o,
    output logic              m_last_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } state_t;

    // Scheduler state
    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Word returning from a FIFO this cycle (issued last cycle)
    logic               inflight_q, inflight_d;
    logic               inflight_ch_q, inflight_ch_d;
    logic               inflight_last_q, inflight_last_d;

    // Two-entry output buffer; entry 0 is always the head
    logic [1:0]         buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0]  buf0_data_q, buf0_data_d;
    logic               buf0_ch_q, buf0_ch_d;
    logic               buf0_last_q, buf0_last_d;
    logic [DATA_W-1:0]  buf1_data_q, buf1_data_d;
    logic               buf1_ch_q, buf1_ch_d;
    logic               buf1_last_q, buf1_last_d;

    logic               m_valid_q, m_valid_d;
    logic               busy_q, busy_d;

    // Combinational helpers
    logic [1:0]         eligible;
    logic               grant_ch;
    logic               sel_empty;
    logic               sel_en;
    logic               pop;
    logic [2:0]         occupancy;
    logic               room;
    logic               can_issue;
    logic               issue;
    logic               capture;
    logic [DATA_W-1:0]  cap_data;

    // Issue decision. The pop of the current head is credited before checking
    // room, so a word can be read every cycle while the downstream accepts.
    // Under backpressure the rule reduces to buffered + in-flight < 2.
    always_comb begin
        eligible  = ch_en_i & ~{ch1_empty_i, ch0_empty_i};
        sel_empty = sel_q ? ch1_empty_i : ch0_empty_i;
        sel_en    = ch_en_i[sel_q];
        pop       = m_valid_q & m_ready_i;
        occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        room      = (occupancy < 3'd2);
        can_issue = enable_i & sel_en & ~sel_empty & (cnt_q < CNT_MAX);
        issue     = (state_q == BURST) & can_issue & room;

`ifdef RD_SCHED_PRIO_EN
        grant_ch  = eligible[0] ? 1'b0 : 1'b1;
`else
        grant_ch  = eligible[rr_q] ? rr_q : ~rr_q;
`endif
    end

    // FIFO read enables come straight from the issue decision, so the current
    // empty flag is honoured in the same cycle.
    always_comb begin
        ch0_rd_en_o = issue & ~sel_q;
        ch1_rd_en_o = issue & sel_q;
    end

    // Next-state logic for the IDLE -> GRANT -> BURST -> IDLE sequence. A full
    // burst returns to IDLE on the cycle that issues its last read, which keeps
    // the gap between back-to-back bursts to one IDLE and one GRANT cycle.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (enable_i && (eligible != 2'b00)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (enable_i && (eligible != 2'b00)) begin
                    sel_d   = grant_ch;
                    cnt_d   = '0;
                    state_d = BURST;
`ifndef RD_SCHED_PRIO_EN
                    rr_d    = ~grant_ch;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (issue) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end else if (!can_issue) begin
                    // Empty, disabled or channel masked: end the burst early.
                    // A room-only stall keeps the burst open.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Track the word whose read was issued this cycle; it arrives next cycle.
    always_comb begin
        inflight_d      = issue;
        inflight_ch_d   = sel_q;
        inflight_last_d = issue & (cnt_q == CNT_LAST);
    end

    // Output buffer update. Pop first (shift entry 1 to the head), then place
    // the returning word behind whatever remains. Capture and pop together
    // leave the count unchanged.
    always_comb begin
        capture  = inflight_q;
        cap_data = inflight_ch_q ? ch1_data_i : ch0_data_i;

        buf_cnt_d   = buf_cnt_q;
        buf0_data_d = buf0_data_q;
        buf0_ch_d   = buf0_ch_q;
        buf0_last_d = buf0_last_q;
        buf1_data_d = buf1_data_q;
        buf1_ch_d   = buf1_ch_q;
        buf1_last_d = buf1_last_q;

        if (pop) begin
            buf0_data_d = buf1_data_q;
            buf0_ch_d   = buf1_ch_q;
            buf0_last_d = buf1_last_q;
            buf_cnt_d   = buf_cnt_q - 2'd1;
        end

        if (capture) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_data_d = cap_data;
                buf0_ch_d   = inflight_ch_q;
                buf0_last_d = inflight_last_q;
            end else begin
                buf1_data_d = cap_data;
                buf1_ch_d   = inflight_ch_q;
                buf1_last_d = inflight_last_q;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        m_valid_d = (buf_cnt_d != 2'd0);
        busy_d    = (state_d != IDLE) | inflight_d | (buf_cnt_d != 2'd0);
    end

    // All scheduler, in-flight and buffer state. Reset discards any word still
    // in flight from a FIFO.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            rr_q            <= 1'b0;
            sel_q           <= 1'b0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_ch_q   <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_cnt_q       <= 2'd0;
            buf0_data_q     <= '0;
            buf0_ch_q       <= 1'b0;
            buf0_last_q     <= 1'b0;
            buf1_data_q     <= '0;
            buf1_ch_q       <= 1'b0;
            buf1_last_q     <= 1'b0;
            m_valid_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            sel_q           <= sel_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            inflight_ch_q   <= inflight_ch_d;
            inflight_last_q <= inflight_last_d;
            buf_cnt_q       <= buf_cnt_d;
            buf0_data_q     <= buf0_data_d;
            buf0_ch_q       <= buf0_ch_d;
            buf0_last_q     <= buf0_last_d;
            buf1_data_q     <= buf1_data_d;
            buf1_ch_q       <= buf1_ch_d;
            buf1_last_q     <= buf1_last_d;
            m_valid_q       <= m_valid_d;
            busy_q          <= busy_d;
        end
    end

    always_comb begin
        m_data_o  = buf0_data_q;
        m_ch_o    = buf0_ch_q;
        m_last_o  = buf0_last_q;
        m_valid_o = m_valid_q;
        busy_o    = busy_q;
    end

endmodule

// File: tb/tb_complex_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_complex_fifo_rd_sched
//
// Directed bench for complex_fifo_rd_sched with BURST_LEN=16. Two behavioural
// FIFOs with 1-cycle read latency feed the scheduler. FIFO words encode the
// channel and read index, so the expected output order can be written down
// from the burst schedule. Honours RD_SCHED_PRIO_EN for the expected order.
// ---------------------------------------------------------------------------
module tb_complex_fifo_rd_sched;

    localparam int BL = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    ch_en = 2'b00;
    logic          ch0_empty, ch1_empty;
    logic [DW-1:0] ch0_data = '0;
    logic [DW-1:0] ch1_data = '0;
    logic          ch0_rd_en, ch1_rd_en;
    logic [DW-1:0] m_data;
    logic          m_ch, m_last, m_valid;
    logic          m_ready = 1'b1;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // FIFO models: totalN = words ever written, readsN = words ever read
    int total0 = 0, total1 = 0;
    int reads0 = 0, reads1 = 0;
    logic underflow = 1'b0;

    // Monitor state
    int  cyc = 0;
    int  rd0_total = 0, rd1_total = 0, xfer_total = 0;
    int  outstanding = 0;
    logic os_viol = 1'b0;
    logic both_rd = 1'b0;
    int  first_rd_cyc = -1, first_valid_cyc = -1;
    int  first_xfer_cyc = -1, last_xfer_cyc = -1;
    logic rand_mode = 1'b0;

    logic [33:0] exp_q [$];

    complex_fifo_rd_sched #(.BURST_LEN(BL), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .ch_en_i     (ch_en),
        .ch0_empty_i (ch0_empty),
        .ch0_data_i  (ch0_data),
        .ch0_rd_en_o (ch0_rd_en),
        .ch1_empty_i (ch1_empty),
        .ch1_data_i  (ch1_data),
        .ch1_rd_en_o (ch1_rd_en),
        .m_data_o    (m_data),
        .m_ch_o      (m_ch),
        .m_last_o    (m_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input int ch, input int idx);
        return ((ch != 0) ? 32'hB100_0000 : 32'hA000_0000) + 32'(idx);
    endfunction

    assign ch0_empty = (reads0 == total0);
    assign ch1_empty = (reads1 == total1);

    // FIFO read ports with one cycle of latency
    always @(posedge clk) begin
        if (ch0_rd_en) begin
            if (reads0 == total0) underflow <= 1'b1;
            ch0_data <= wordOf(0, reads0);
            reads0   <= reads0 + 1;
        end
        if (ch1_rd_en) begin
            if (reads1 == total1) underflow <= 1'b1;
            ch1_data <= wordOf(1, reads1);
            reads1   <= reads1 + 1;
        end
        cyc <= cyc + 1;
    end

    // Downstream ready, changed just after the clock edge
    always begin
        @(posedge clk);
        #1;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (ch0_rd_en && ch1_rd_en) both_rd = 1'b1;
            if (ch0_rd_en) rd0_total++;
            if (ch1_rd_en) rd1_total++;
            if ((ch0_rd_en || ch1_rd_en) && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_total++;
                if (exp_q.size() > 0)
                    checkOutput("word", 64'({m_ch, m_last, m_data}), 64'(exp_q.pop_front()));
                else
                    checkOutput("extra_word", 64'({m_ch, m_last, m_data}), 64'hFFFF_FFFF_FFFF_FFFF);
            end
            outstanding = outstanding + int'(ch0_rd_en | ch1_rd_en) - int'(m_valid & m_ready);
            if (outstanding > 2) os_viol = 1'b1;
        end
    end

    // Expected order for n0/n1 new words, starting from a fresh pointer (ch0)
    task automatic buildExpected(input int n0, input int n1);
        int rem [2];
        int nxt [2];
        int k;
        int g;
`ifndef RD_SCHED_PRIO_EN
        int ptr = 0;
`endif
        rem[0] = n0; rem[1] = n1;
        nxt[0] = reads0; nxt[1] = reads1;
        while (rem[0] > 0 || rem[1] > 0) begin
`ifdef RD_SCHED_PRIO_EN
            g = (rem[0] > 0) ? 0 : 1;
`else
            g = (rem[ptr] > 0) ? ptr : 1 - ptr;
            ptr = 1 - g;
`endif
            k = (rem[g] < BL) ? rem[g] : BL;
            for (int i = 0; i < k; i++)
                exp_q.push_back({g[0], (k == BL && i == BL - 1), wordOf(g, nxt[g] + i)});
            nxt[g] += k;
            rem[g] -= k;
        end
    endtask

    task automatic resetDut();
        enable = 1'b0;
        ch_en = 2'b00;
        rand_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total0 = reads0;
        total1 = reads1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        first_rd_cyc = -1; first_valid_cyc = -1;
        first_xfer_cyc = -1; last_xfer_cyc = -1;
    endtask

    task automatic applyStimulus(input int n0, input int n1, input logic [1:0] mask,
                                 input logic rnd);
        @(negedge clk);
        rand_mode = rnd;
        ch_en = mask;
        total0 += n0;
        total1 += n1;
        enable = 1'b1;
    endtask

    task automatic waitDrain(input string tag, input int max_cyc);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checkOutput({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_data"},  64'(m_data),  64'd0);
        checkOutput({tag, "_ch"},    64'(m_ch),    64'd0);
        checkOutput({tag, "_last"},  64'(m_last),  64'd0);
        checkOutput({tag, "_busy"},  64'(busy),    64'd0);
        checkOutput({tag, "_rd0"},   64'(ch0_rd_en), 64'd0);
        checkOutput({tag, "_rd1"},   64'(ch1_rd_en), 64'd0);
    endtask

    initial begin
        int s0, s1, sx, n;

        // Reset state
        #12;
        checkIdleOutputs("reset");
        resetDut();

        // Test 1: both FIFOs 40 words, ready held high
        sx = xfer_total;
        buildExpected(40, 40);
        applyStimulus(40, 40, 2'b11, 1'b0);
        waitDrain("t1", 400);
        checkOutput("t1_count", 64'(xfer_total - sx), 64'd80);
        checkOutput("t1_latency", 64'(first_valid_cyc - first_rd_cyc), 64'd2);
        checkOutput("t1_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'd90);

        // Test 2: only ch1 has 5 words
        resetDut();
        s0 = rd0_total; sx = xfer_total;
        buildExpected(0, 5);
        applyStimulus(0, 5, 2'b11, 1'b0);
        waitDrain("t2", 100);
        checkOutput("t2_count", 64'(xfer_total - sx), 64'd5);
        checkOutput("t2_busy", 64'(busy), 64'd0);
        checkOutput("t2_rd0", 64'(rd0_total - s0), 64'd0);
        checkOutput("t2_latency", 64'(first_valid_cyc - first_rd_cyc), 64'd2);

        // Test 3: 100 words each, random backpressure
        resetDut();
        sx = xfer_total;
        os_viol = 1'b0;
        buildExpected(100, 100);
        applyStimulus(100, 100, 2'b11, 1'b1);
        waitDrain("t3", 5000);
        rand_mode = 1'b0;
        checkOutput("t3_count", 64'(xfer_total - sx), 64'd200);
        checkOutput("t3_overfill", 64'(os_viol), 64'd0);

        // Test 4: reset pulse with the ch0 burst counter at 7
        resetDut();
        s0 = rd0_total;
        buildExpected(40, 40);
        applyStimulus(40, 40, 2'b11, 1'b0);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            if (rd0_total - s0 >= 7) break;
        end
        checkOutput("t4_rd0_at_reset", 64'(rd0_total - s0), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("t4_async");
        total0 = reads0;
        total1 = reads1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("t4_post");
        sx = xfer_total;
        buildExpected(20, 20);
        applyStimulus(20, 20, 2'b11, 1'b0);
        waitDrain("t4", 300);
        checkOutput("t4_count", 64'(xfer_total - sx), 64'd40);

        // Test 5: ch1 masked off five reads into its burst
        resetDut();
        s0 = rd0_total; s1 = rd1_total;
        for (int i = 0; i < 5; i++)
            exp_q.push_back({1'b1, 1'b0, wordOf(1, reads1 + i)});
        applyStimulus(0, 20, 2'b11, 1'b0);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            if (rd1_total - s1 >= 5) break;
        end
        #1;
        ch_en = 2'b01;
        buildExpected(10, 0);
        total0 += 10;
        waitDrain("t5", 200);
        checkOutput("t5_rd1", 64'(rd1_total - s1), 64'd5);
        checkOutput("t5_rd0", 64'(rd0_total - s0), 64'd10);

        // Global protocol flags
        checkOutput("both_rd_en", 64'(both_rd), 64'd0);
        checkOutput("fifo_underflow", 64'(underflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
